// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and geometry constants.
// Functions work on zero-extended 32-bit values, so any width up to 32 is served.
package fifo_pkg;

    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle between the FIFO consumer and the read controller.
// The consumer (master) issues requests; the controller (slave) reports status.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  r_inc;
    logic                  r_clr_err;
    logic                  r_ae_load;
    logic [ADDR_WIDTH:0]   r_ae_in;
    logic [ADDR_WIDTH:0]   rq2_wptr;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_ptr;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_valid;
    logic                  r_underflow;

    modport master (
        output r_inc, r_clr_err, r_ae_load, r_ae_in, rq2_wptr,
        input  r_en, r_addr, r_ptr, r_empty, r_almost_empty,
        input  r_level, r_valid, r_underflow
    );

    modport slave (
        input  r_inc, r_clr_err, r_ae_load, r_ae_in, rq2_wptr,
        output r_en, r_addr, r_ptr, r_empty, r_almost_empty,
        output r_level, r_valid, r_underflow
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix chain from the MSB).
// Shared by the read- and write-side pointer controllers.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    always_comb begin
        bin = gray;
        for (int i = W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: read pointer, empty/almost-empty,
// occupancy, RAM read strobe with data-valid, and sticky underflow.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AE_RESET   = 1
) (
    input logic            R_CLK,
    input logic            R_RST,
    fifo_rd_ctrl_if.slave  bus
);
    import fifo_pkg::*;

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_bin_next;
    logic [PW-1:0] r_gray_next;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] thresh;
    logic          accept;

    fifo_gray2bin #(
        .W    (PW)
    ) u_wptr_g2b (
        .gray (bus.rq2_wptr),
        .bin  (w_bin)
    );

    assign accept      = bus.r_inc & ~bus.r_empty;
    assign bus.r_en    = accept;
    assign bus.r_addr  = r_bin[ADDR_WIDTH-1:0];
    assign r_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, accept};
    assign r_gray_next = PW'(bin2gray(32'(r_bin_next)));
    // Modular difference is always 0..DEPTH while the writer respects full.
    assign level_next  = w_bin - r_bin_next;

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            r_bin              <= '0;
            bus.r_ptr          <= '0;
            bus.r_empty        <= 1'b1;
            bus.r_level        <= '0;
            bus.r_almost_empty <= 1'b1;
            bus.r_valid        <= 1'b0;
        end else begin
            r_bin              <= r_bin_next;
            bus.r_ptr          <= r_gray_next;
            bus.r_empty        <= (r_gray_next == bus.rq2_wptr);
            bus.r_level        <= level_next;
            bus.r_almost_empty <= (level_next <= thresh);
            bus.r_valid        <= accept;
        end
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            thresh <= PW'(AE_RESET);
        end else if (bus.r_ae_load) begin
            thresh <= bus.r_ae_in;
        end
    end

    // Set has priority so a clear cannot hide a fresh underflow.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            bus.r_underflow <= 1'b0;
        end else if (bus.r_inc & bus.r_empty) begin
            bus.r_underflow <= 1'b1;
        end else if (bus.r_clr_err) begin
            bus.r_underflow <= 1'b0;
        end
    end

endmodule
